nf_ram_ctrl: RTL and testbench
==============================

# nf_ram_ctrl

Bus-slave controller between the core's data-memory bus and the word-wide `nf_ram` array. It converts byte addresses to word indices and returns read data on a request/acknowledge handshake. Because `nf_ram` only writes whole words, it performs byte and halfword stores as read-modify-write sequences. It also rejects misaligned and out-of-range accesses with an error acknowledge.

## Interface
- `depth`, 64: word count of the attached `nf_ram`; word indices `>= depth` are out of range.

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req` in 1: access request; held by the requester until `ack`.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `size` in 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `wd` in 32: store data, right-aligned: byte in [7:0], halfword in [15:0].
- `rd` out 32: load data, right-aligned and zero-extended; valid when `ack` = 1 and `err` = 0.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: asserted together with `ack` when the access is rejected.
- `ram_addr` out 32: word index to `nf_ram`, equal to `{2'b00, addr_q[31:2]}`.
- `ram_we` out 1: write enable to `nf_ram`.
- `ram_wd` out 32: write data to `nf_ram`.
- `ram_rd` in 32: combinational read data from `nf_ram`.

## Operation
States are IDLE, RD, WR, ACK and ERR.

- **IDLE**
  - If `req` = 1, latch `addr`, `we`, `size` and `wd` into `*_q` registers.
  - Run the legality check:
    - `size` = 11 is illegal.
    - A halfword with `addr[0]` = 1 is illegal.
    - A word with `addr[1:0]` ≠ 0 is illegal.
    - A word index `>= depth` is illegal.
  - Illegal access → ERR.
  - Legal load, or legal sub-word store → RD.
  - Legal word store → WR.
- **RD**
  - Sample `ram_rd` into `word_q`.
  - Load → ACK. Also register `rd`:
    - word: `ram_rd`.
    - halfword: `ram_rd[16*addr_q[1] +: 16]`, zero-extended.
    - byte: `ram_rd[8*addr_q[1:0] +: 8]`, zero-extended.
  - Store → WR.
- **WR**
  - `ram_we` = 1.
  - Word store: `ram_wd` = `wd_q`.
  - Sub-word store: `ram_wd` = `word_q` with the addressed byte or halfword lane replaced by `wd_q[7:0]` or `wd_q[15:0]`. All other lanes keep their old values.
  - → ACK.
- **ACK**: `ack` = 1, `err` = 0 → IDLE.
- **ERR**: `ack` = 1, `err` = 1, no RAM write, `rd` unchanged → IDLE.

Other rules:
- `ram_addr` is driven from `addr_q` in every state except IDLE; in IDLE it holds its last value.
- `ram_we` = (state == WR) & ~`reset`. A reset asserted during the WR cycle suppresses the write.
- `ram_wd` is 0 outside WR.
- `req` is sampled only in IDLE. If `req` is still high in the IDLE cycle after `ack`, it is a new request. The requester drops `req` in the `ack` cycle unless it intends back-to-back accesses.
- Changes to `addr`, `we`, `size` or `wd` after the request is accepted have no effect.

## Timing
Reset (synchronous, active-high) forces state to IDLE and the following values:
- `ack` = 0, `err` = 0, `rd` = 0
- `ram_we` = 0, `ram_addr` = 0, `ram_wd` = 0
- `word_q` = 0; all `*_q` registers = 0

An access in flight is abandoned without a write or an `ack`.

Latency is counted from the edge at which IDLE samples `req` (edge 0):
- Load: `ack` high in cycle 2.
- Word store: write at edge 2, `ack` in cycle 2.
- Sub-word store: write at edge 3, `ack` in cycle 3.
- Error: `ack` + `err` in cycle 1.

Other timing rules:
- Minimum spacing between accepted requests is one IDLE cycle after each `ack`. Throughput is therefore one load per 3 cycles and one sub-word store per 4 cycles.
- `rd` holds its value until the next load completes.

## Test plan
- **Reset**: assert `reset` for 2 cycles with `req` = 1 → all outputs 0 and no `ram_we` pulse; after release, `ack` appears exactly 2 cycles after the first IDLE sample.
- **Word store then load**: store 0xDEADBEEF to addr 0x10, then load word from 0x10.
  - Store: `ram_addr` = 4 and one `ram_we` pulse.
  - Load: `rd` = 0xDEADBEEF; `ack` latencies are 2 and 2.
- **Byte RMW**: preload word 3 = 0x11223344; store byte 0xAA to addr 0x0D → word 3 = 0x1122AA44. A byte load from 0x0D then returns 0x000000AA.
- **Halfword**:
  - Store 0xBEEF to addr 0x0E over 0x11223344 → 0xBEEF3344, with `ack` at cycle 3.
  - Load halfword from 0x0C → 0x00003344.
- **Errors**: each access below → `ack` = `err` = 1 in cycle 1, no `ram_we`, RAM unchanged.
  - halfword at 0x01
  - word at 0x02
  - `size` = 11
  - word at 4*`depth`
- **Reset mid-op and back-to-back**:
  - Assert `reset` during the WR cycle of a byte store → RAM word unchanged, `ack` never asserted.
  - Hold `req` high across `ack` → second access starts in the following IDLE cycle and completes normally.

Source files
------------

// File: rtl/nf_ram_ctrl.sv
// nf_ram_ctrl: bus-slave front end for the word-wide nf_ram array.
// Translates byte addresses to word indices, performs read-modify-write for
// byte/halfword stores, and rejects misaligned or out-of-range accesses.
module nf_ram_ctrl #(
    parameter int unsigned depth = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    localparam int unsigned IDX_W     = 30;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(depth);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK,
        S_ERR
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] wd_q;
    logic [31:0] word_q;

    logic        legal_c;
    logic [31:0] rd_sel_c;
    logic [31:0] merge_c;

    // Legality of the access currently presented on the bus
    always_comb begin
        legal_c = 1'b1;
        case (size)
            SZ_BYTE: legal_c = 1'b1;
            SZ_HALF: if (addr[0]) legal_c = 1'b0;
            SZ_WORD: if (addr[1:0] != 2'b00) legal_c = 1'b0;
            default: legal_c = 1'b0;
        endcase
        if (addr[31:2] >= DEPTH_IDX) begin
            legal_c = 1'b0;
        end
    end

    // Right-aligned, zero-extended lane extraction for loads
    always_comb begin
        rd_sel_c = ram_rd;
        case (size_q)
            SZ_BYTE: rd_sel_c = {24'h0, ram_rd[{addr_q[1:0], 3'b000} +: 8]};
            SZ_HALF: rd_sel_c = {16'h0, ram_rd[{addr_q[1], 4'b0000} +: 16]};
            default: rd_sel_c = ram_rd;
        endcase
    end

    // Store word: full word for word stores, old word with one lane replaced otherwise
    always_comb begin
        merge_c = word_q;
        case (size_q)
            SZ_BYTE: merge_c[{addr_q[1:0], 3'b000} +: 8]  = wd_q[7:0];
            SZ_HALF: merge_c[{addr_q[1], 4'b0000} +: 16]  = wd_q[15:0];
            default: merge_c = wd_q;
        endcase
    end

    // RAM port: addr_q only moves on acceptance, so it already holds its value in IDLE
    assign ram_addr = {2'b00, addr_q[31:2]};
    assign ram_we   = (state == S_WR) & ~reset;
    assign ram_wd   = (state == S_WR) ? merge_c : 32'h0;

    // Access sequencer with registered handshake and load data
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            addr_q <= 32'h0;
            we_q   <= 1'b0;
            size_q <= 2'b00;
            wd_q   <= 32'h0;
            word_q <= 32'h0;
            rd     <= 32'h0;
            ack    <= 1'b0;
            err    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        we_q   <= we;
                        size_q <= size;
                        wd_q   <= wd;
                        if (!legal_c) begin
                            state <= S_ERR;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end else if (we && (size == SZ_WORD)) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    word_q <= ram_rd;
                    if (we_q) begin
                        state <= S_WR;
                    end else begin
                        rd    <= rd_sel_c;
                        ack   <= 1'b1;
                        state <= S_ACK;
                    end
                end
                S_WR: begin
                    ack   <= 1'b1;
                    state <= S_ACK;
                end
                S_ACK:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_ram_ctrl.sv
// Scoreboard bench for nf_ram_ctrl with a behavioural word-array reference model.
module tb_nf_ram_ctrl;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [31:0] addr, wd, rd, ram_addr, ram_wd, ram_rd;
    logic [1:0]  size;
    logic        ack, err, ram_we;

    always #5 clk = ~clk;

    nf_ram_ctrl #(.depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
        .wd(wd), .rd(rd), .ack(ack), .err(err), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    // Attached nf_ram: combinational read, whole-word write on the clock edge
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (ram_we && ram_addr < DEPTH) mem[ram_addr[5:0]] <= ram_wd;
    assign ram_rd = (ram_addr < DEPTH) ? mem[ram_addr[5:0]] : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        int          ack_cyc;
        logic        chk_rd;
        logic [31:0] rd;
        int          we_pulses;
        logic [31:0] idx;
        logic        chk_mem;
        logic [31:0] mem_word;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [31:0] we_addr = 32'h0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] ref_rd = 32'h0;
    bit          rd_known = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: apply the access to the word array and push the expected response
    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input int edge0);
        exp_t        e;
        logic [31:0] idx;
        logic [31:0] word;
        int unsigned sh;
        bit          legal;
        int          lat;
        idx   = a / 4;
        legal = (s != 2'd3) && !(s == 2'd1 && (a % 2) != 0)
                && !(s == 2'd2 && (a % 4) != 0) && (idx < DEPTH);
        e.err = !legal;
        e.we_pulses = 0;
        e.idx = idx;
        e.chk_mem = 1'b0;
        e.mem_word = 32'h0;
        if (!legal) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            if (ref_known[idx[5:0]]) begin
                word = ref_mem[idx[5:0]];
                if (s == 2'd0)      ref_rd = (word >> (8 * (a % 4))) & 32'hFF;
                else if (s == 2'd1) ref_rd = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                else                ref_rd = word;
                rd_known = 1'b1;
            end else begin
                rd_known = 1'b0;
            end
        end else begin
            e.we_pulses = 1;
            if (s == 2'd2) begin
                lat = 2;
                ref_mem[idx[5:0]] = d;
                ref_known[idx[5:0]] = 1'b1;
            end else begin
                lat  = 3;
                word = ref_mem[idx[5:0]];
                if (s == 2'd0) begin
                    sh = 8 * (a % 4);
                    ref_mem[idx[5:0]] = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
                end else begin
                    sh = 16 * ((a % 4) / 2);
                    ref_mem[idx[5:0]] = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
                end
            end
        end
        if (idx < DEPTH && ref_known[idx[5:0]]) begin
            e.chk_mem  = 1'b1;
            e.mem_word = ref_mem[idx[5:0]];
        end
        e.chk_rd  = rd_known;
        e.rd      = ref_rd;
        e.ack_cyc = edge0 + lat - 1;
        sb.push_back(e);
    endtask

    task automatic scramble();
        we   = 1'($urandom);
        size = 2'($urandom);
        addr = $urandom;
        wd   = $urandom;
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack within 10 cycles (t=%0t)", $time);
        end
    endtask

    task automatic run(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        we = w; size = s; addr = a; wd = d; req = 1'b1;
        issue(w, s, a, d, cyc + 1);
        @(posedge clk); #1;
        scramble();
        wait_ack();
        req = 1'b0;
    endtask

    // Second request held on req across the first ack
    task automatic run_b2b(input logic w1, input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic w2, input logic [1:0] s2, input logic [31:0] a2, input logic [31:0] d2);
        @(posedge clk); #1;
        we = w1; size = s1; addr = a1; wd = d1; req = 1'b1;
        issue(w1, s1, a1, d1, cyc + 1);
        @(posedge clk); #1;
        scramble();
        wait_ack();
        we = w2; size = s2; addr = a2; wd = d2;
        issue(w2, s2, a2, d2, cyc + 2);
        @(posedge clk);
        @(posedge clk); #1;
        scramble();
        wait_ack();
        req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 6) return $urandom_range(DEPTH * 4, 32'hFFFF_FFFF);
        return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [1:0] rand_size();
        if ($urandom_range(0, 99) < 6) return 2'd3;
        return 2'($urandom_range(0, 2));
    endfunction

    // Monitor: compare every ack against the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                we_cnt = 0;
            end else begin
                if (ram_we) begin
                    we_cnt++;
                    we_addr = ram_addr;
                end
                if (ack) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'h0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("err", 32'(err), 32'(mon_e.err));
                        check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                        check("we_pulses", 32'(we_cnt), 32'(mon_e.we_pulses));
                        if (mon_e.chk_rd) check("rd", rd, mon_e.rd);
                        if (mon_e.we_pulses == 1) check("we_addr", we_addr, mon_e.idx);
                        if (mon_e.chk_mem) check("mem_word", mem[mon_e.idx[5:0]], mon_e.mem_word);
                    end
                    we_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ack_seen;
        reset = 1'b1; req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0; wd = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Reset held two cycles with req high
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_ack", 32'(ack), 32'h0);
            check("rst_err", 32'(err), 32'h0);
            check("rst_rd", rd, 32'h0);
            check("rst_ram_we", 32'(ram_we), 32'h0);
            check("rst_ram_addr", ram_addr, 32'h0);
            check("rst_ram_wd", ram_wd, 32'h0);
        end
        reset = 1'b0;
        issue(1'b0, 2'd2, 32'h0, 32'h0, cyc + 1);
        @(posedge clk); #1;
        scramble();
        wait_ack();
        req = 1'b0;

        // Fill the array through word stores
        for (int i = 0; i < DEPTH; i++) run(1'b1, 2'd2, 32'(i) * 4, $urandom);
        run(1'b0, 2'd2, 32'h0, 32'h0);

        // Word store then load
        run(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        check("dir_mem4", mem[4], 32'hDEADBEEF);
        run(1'b0, 2'd2, 32'h10, 32'h0);
        check("dir_rd_word", rd, 32'hDEADBEEF);

        // Byte read-modify-write
        run(1'b1, 2'd2, 32'h0C, 32'h11223344);
        run(1'b1, 2'd0, 32'h0D, 32'h000000AA);
        check("dir_byte_rmw", mem[3], 32'h1122AA44);
        run(1'b0, 2'd0, 32'h0D, 32'h0);
        check("dir_rd_byte", rd, 32'h000000AA);

        // Halfword store and load
        run(1'b1, 2'd2, 32'h0C, 32'h11223344);
        run(1'b1, 2'd1, 32'h0E, 32'h0000BEEF);
        check("dir_half_rmw", mem[3], 32'hBEEF3344);
        run(1'b0, 2'd1, 32'h0C, 32'h0);
        check("dir_rd_half", rd, 32'h00003344);

        // Rejected accesses
        run(1'b0, 2'd1, 32'h01, 32'h0);
        run(1'b1, 2'd2, 32'h02, $urandom);
        run(1'b0, 2'd3, 32'h20, 32'h0);
        run(1'b1, 2'd2, DEPTH * 4, $urandom);

        // Reset during the write cycle of a byte store
        @(posedge clk); #1;
        we = 1'b1; size = 2'd0; addr = 32'h15; wd = 32'h5A; req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_we_before_rst", 32'(ram_we), 32'h1);
        reset = 1'b1; req = 1'b0;
        #1;
        check("mid_we_gated", 32'(ram_we), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) ack_seen = 1'b1;
        end
        check("mid_no_ack", 32'(ack_seen), 32'h0);
        check("mid_mem_kept", mem[5], ref_mem[5]);
        check("mid_rd_cleared", rd, 32'h0);
        ref_rd = 32'h0;
        rd_known = 1'b1;

        // Back-to-back accesses
        run_b2b(1'b1, 2'd0, 32'h21, 32'h77, 1'b0, 2'd2, 32'h20, 32'h0);
        run_b2b(1'b0, 2'd1, 32'h03, 32'h0, 1'b1, 2'd1, 32'h32, 32'hCAFE);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0)
                run_b2b(1'($urandom), rand_size(), rand_addr(), $urandom,
                        1'($urandom), rand_size(), rand_addr(), $urandom);
            else
                run(1'($urandom), rand_size(), rand_addr(), $urandom);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
